// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage constants, the buffered entry layout and a word-alignment helper.
package if_fetch_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_instr_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally from storage so a
// pushed entry becomes visible the cycle after the push.
module if_instr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_W = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_eff, pop_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == DEPTH_W);
  assign count_o  = count_q;
  assign head_o   = mem_q[rd_ptr_q];
  assign pop_eff  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_eff = push_i && (!full_o || pop_eff);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_n_i)
                   !(push_i && full_o && !pop_eff && !flush_i))
    else $error("if_instr_fifo: push into full FIFO");
`endif

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word reads, buffers
// responses with their addresses and hands {instr, pc} to ID; redirects flush and drop.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_n_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          run_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  fetch_entry_t  fifo_head, fifo_push_data;
  logic          fifo_push, fifo_pop;

  logic [31:0]   addr_head;
  logic [CW-1:0] addr_count;
  logic          addr_empty, addr_full, addr_pop;

  logic [CW:0]   credit_used;
  logic          req_fire, dropping;

  // Buffered entries plus outstanding reads never exceed the FIFO depth.
  assign credit_used      = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign imem_req_valid_o = run_q && (credit_used < DEPTH_W) && !redirect_valid_i;
  assign imem_addr_o      = pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign dropping         = (drop_q != '0);

  assign addr_pop       = imem_rsp_valid_i && !dropping;
  assign fifo_push      = imem_rsp_valid_i && !dropping && !redirect_valid_i;
  assign fifo_pop       = instr_valid_o && id_ready_i && !redirect_valid_i;
  assign fifo_push_data = '{pc: addr_head, instr: imem_rsp_data_i};

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = instr_valid_o ? fifo_head.instr : INSTR_NOP;
  assign pc_o          = instr_valid_o ? fifo_head.pc : 32'h0;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
    drop_d     = drop_q;
    if (redirect_valid_i) begin
      pc_d   = align_word(redirect_pc_i);
      // Everything still outstanding after this edge belongs to the old stream.
      drop_d = inflight_d;
    end else begin
      if (req_fire)                     pc_d   = pc_q + PC_STEP;
      if (imem_rsp_valid_i && dropping) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
    if (!rst_sys_n_i) begin
      pc_q       <= align_word(RESET_PC);
      inflight_q <= '0;
      drop_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      run_q      <= 1'b1;
    end
  end

  // Addresses of live (non-dropped) reads, matched to responses in order.
  if_instr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_addr_q (
    .clk_i       (clk_sys_i),
    .rst_n_i     (rst_sys_n_i),
    .push_i      (req_fire),
    .push_data_i (pc_q),
    .pop_i       (addr_pop),
    .flush_i     (redirect_valid_i),
    .head_o      (addr_head),
    .full_o      (addr_full),
    .empty_o     (addr_empty),
    .count_o     (addr_count)
  );

  if_instr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_instr_fifo (
    .clk_i       (clk_sys_i),
    .rst_n_i     (rst_sys_n_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_valid_i),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  logic unused_flags;
  assign unused_flags = ^{addr_full, addr_empty, addr_count, fifo_full};

endmodule
